// File: rtl/pc_pkg.sv
// Shared types for the program-counter sequencer: run state and per-cycle PC action.
package pc_pkg;

   typedef enum logic [1:0] {IDLE, RUN, DONE} pc_state_t;

   typedef enum logic [2:0] {OP_INC, OP_REL, OP_ABS, OP_CALL, OP_RET, OP_HOLD} pc_op_t;

   // Only the highest-priority request acts; stall overrides everything.
   function automatic pc_op_t pc_op_sel(input logic stall, input logic ret,
                                        input logic call, input logic abs,
                                        input logic rel);
      pc_op_t op;
      if (stall)     op = OP_HOLD;
      else if (ret)  op = OP_RET;
      else if (call) op = OP_CALL;
      else if (abs)  op = OP_ABS;
      else if (rel)  op = OP_REL;
      else           op = OP_INC;
      return op;
   endfunction

endpackage

// File: rtl/ret_stack.sv
// Return-address LIFO. Push when full and pop when empty are ignored; the caller flags them.
module ret_stack #(
   parameter int D           = 12,
   parameter int STACK_DEPTH = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic         pop,
   input  logic         clear,
   input  logic [D-1:0] din,
   output logic [D-1:0] dout,
   output logic         full,
   output logic         empty
);

   localparam int PW = $clog2(STACK_DEPTH + 1);

   logic [PW-1:0] sp_q, sp_d;
   logic [D-1:0]  mem_q [STACK_DEPTH];

   assign full  = (sp_q == PW'(STACK_DEPTH));
   assign empty = (sp_q == '0);

   always_comb begin
      sp_d = sp_q;
      if (clear)               sp_d = '0;
      else if (push && !full)  sp_d = sp_q + PW'(1);
      else if (pop && !empty)  sp_d = sp_q - PW'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) sp_q <= '0;
      else     sp_q <= sp_d;
   end

   // Storage needs no reset: entries above the stack pointer are never read.
   always_ff @(posedge clk) begin
      for (int i = 0; i < STACK_DEPTH; i++)
         if (push && !full && !clear && sp_q == PW'(i)) mem_q[i] <= din;
   end

   always_comb begin
      dout = '0;
      for (int i = 0; i < STACK_DEPTH; i++)
         if (sp_q == PW'(i + 1)) dout = mem_q[i];
   end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage PC sequencer with req/done handshake, call/return stack and sticky stack errors.
// Optional retired-instruction counter enabled by defining PC_INSTR_COUNT_EN.
module pc_sequencer
   import pc_pkg::*;
#(
   parameter int D           = 12,
   parameter int START_ADDR  = 0,
   parameter int END_ADDR    = 128,
   parameter int STACK_DEPTH = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         req,
   input  logic         stall,
   input  logic         reljump_en,
   input  logic         absjump_en,
   input  logic         call_en,
   input  logic         ret_en,
   input  logic [D-1:0] target,
   output logic [D-1:0] prog_ctr,
   output logic         busy,
   output logic         done,
   output logic         stack_ovf,
   output logic         stack_unf,
   output logic [31:0]  instr_cnt
);

   localparam logic [D-1:0] START_PC = D'(START_ADDR);
   localparam logic [D-1:0] END_PC   = D'(END_ADDR);

   pc_state_t    state_q, state_d;
   logic [D-1:0] pc_q, pc_d;
   logic         ovf_q, ovf_d, unf_q, unf_d;
   logic         push, pop, stk_clr, cnt_en, cnt_clr;
   logic [D-1:0] stk_dout;
   logic         stk_full, stk_empty;
   pc_op_t       op;

   assign op = pc_op_sel(stall, ret_en, call_en, absjump_en, reljump_en);

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      ovf_d   = ovf_q;
      unf_d   = unf_q;
      push    = 1'b0;
      pop     = 1'b0;
      stk_clr = 1'b0;
      cnt_en  = 1'b0;
      cnt_clr = 1'b0;
      case (state_q)
         IDLE, DONE: begin
            if (state_q == IDLE) pc_d = START_PC;
            if (req) begin
               state_d = RUN;
               pc_d    = START_PC;
               ovf_d   = 1'b0;
               unf_d   = 1'b0;
               stk_clr = 1'b1;
               cnt_clr = 1'b1;
            end
         end
         RUN: begin
            // The END_ADDR slot never executes, so requests there are dropped.
            if (!stall && pc_q == END_PC) begin
               state_d = DONE;
            end else if (!stall) begin
               cnt_en = 1'b1;
               case (op)
                  OP_RET: begin
                     if (stk_empty) begin
                        unf_d = 1'b1;
                        pc_d  = pc_q + D'(1);
                     end else begin
                        pop  = 1'b1;
                        pc_d = stk_dout;
                     end
                  end
                  OP_CALL: begin
                     if (stk_full) ovf_d = 1'b1;
                     else          push  = 1'b1;
                     pc_d = target;
                  end
                  OP_ABS:  pc_d = target;
                  OP_REL:  pc_d = pc_q + target;
                  OP_INC:  pc_d = pc_q + D'(1);
                  default: pc_d = pc_q;
               endcase
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         pc_q    <= START_PC;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ovf_q   <= ovf_d;
         unf_q   <= unf_d;
      end
   end

   ret_stack #(.D(D), .STACK_DEPTH(STACK_DEPTH)) u_stack (
      .clk   (clk),
      .rst   (reset),
      .push  (push),
      .pop   (pop),
      .clear (stk_clr),
      .din   (pc_q + D'(1)),
      .dout  (stk_dout),
      .full  (stk_full),
      .empty (stk_empty)
   );

`ifdef PC_INSTR_COUNT_EN
   logic [31:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (cnt_clr)                             cnt_d = '0;
      else if (cnt_en && cnt_q != 32'hFFFF_FFFF) cnt_d = cnt_q + 32'd1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

   assign instr_cnt = cnt_q;
`else
   logic unused_cnt;
   assign unused_cnt = cnt_en ^ cnt_clr;
   assign instr_cnt  = '0;
`endif

   assign prog_ctr  = pc_q;
   assign busy      = (state_q == RUN);
   assign done      = (state_q == DONE);
   assign stack_ovf = ovf_q;
   assign stack_unf = unf_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer (D=12, START_ADDR=0, END_ADDR=128, STACK_DEPTH=4).
module tb_pc_sequencer;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        req = 1'b0, stall = 1'b0, reljump_en = 1'b0, absjump_en = 1'b0;
   logic        call_en = 1'b0, ret_en = 1'b0;
   logic [11:0] target = '0;
   logic [11:0] prog_ctr;
   logic        busy, done, stack_ovf, stack_unf;
   logic [31:0] instr_cnt;

   int n_cmp = 0;
   int n_bad = 0;

   pc_sequencer #(.D(12), .START_ADDR(0), .END_ADDR(128), .STACK_DEPTH(4)) dut (
      .clk(clk), .reset(reset), .req(req), .stall(stall),
      .reljump_en(reljump_en), .absjump_en(absjump_en), .call_en(call_en),
      .ret_en(ret_en), .target(target), .prog_ctr(prog_ctr), .busy(busy),
      .done(done), .stack_ovf(stack_ovf), .stack_unf(stack_unf), .instr_cnt(instr_cnt)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] exp_cnt(input int n);
`ifdef PC_INSTR_COUNT_EN
      return 32'(n);
`else
      return 32'd0 + 32'(n * 0);
`endif
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_ctl();
      req = 0; stall = 0; reljump_en = 0; absjump_en = 0; call_en = 0; ret_en = 0; target = '0;
   endtask

   // Fresh run: reset, then a one-cycle req; leaves RUN at PC 0 with empty stack.
   task automatic go();
      idle_ctl();
      reset = 1; #2; reset = 0;
      req = 1; step(); req = 0;
   endtask

   task automatic test_reset();
      idle_ctl();
      reset = 1; step();
      n_cmp++;
      if (prog_ctr !== 12'd0 || busy !== 1'b0 || done !== 1'b0 || stack_ovf !== 1'b0 ||
          stack_unf !== 1'b0 || instr_cnt !== 32'd0) begin
         n_bad++;
         $display("FAIL reset_state got pc=%0d busy=%b done=%b ovf=%b unf=%b cnt=%0d want 0,0,0,0,0,0",
                  prog_ctr, busy, done, stack_ovf, stack_unf, instr_cnt);
      end
      reset = 0;
      absjump_en = 1; target = 12'd55; step(); step();
      n_cmp++;
      if (prog_ctr !== 12'd0 || busy !== 1'b0) begin
         n_bad++;
         $display("FAIL idle_ignores_ctl got pc=%0d busy=%b want pc=0 busy=0", prog_ctr, busy);
      end
      idle_ctl();
   endtask

   task automatic test_run_to_end();
      idle_ctl();
      req = 1; step(); req = 0;
      repeat (37) step();
      n_cmp++;
      if (prog_ctr !== 12'd37 || busy !== 1'b1) begin
         n_bad++;
         $display("FAIL run_pc37 got pc=%0d busy=%b want pc=37 busy=1", prog_ctr, busy);
      end
      reset = 1; #1;
      n_cmp++;
      if (prog_ctr !== 12'd0 || busy !== 1'b0 || instr_cnt !== 32'd0) begin
         n_bad++;
         $display("FAIL async_reset got pc=%0d busy=%b cnt=%0d want 0,0,0", prog_ctr, busy, instr_cnt);
      end
      #1; reset = 0;
      req = 1; step(); req = 0;
      n_cmp++;
      if (prog_ctr !== 12'd0 || busy !== 1'b1) begin
         n_bad++;
         $display("FAIL start got pc=%0d busy=%b want pc=0 busy=1", prog_ctr, busy);
      end
      for (int i = 1; i <= 128; i++) begin
         step();
         n_cmp++;
         if (prog_ctr !== 12'(i) || done !== 1'b0) begin
            n_bad++;
            $display("FAIL count_seq got pc=%0d done=%b want pc=%0d done=0", prog_ctr, done, i);
         end
      end
      step();
      n_cmp++;
      if (done !== 1'b1 || busy !== 1'b0 || prog_ctr !== 12'd128 || instr_cnt !== exp_cnt(128)) begin
         n_bad++;
         $display("FAIL end_done got done=%b busy=%b pc=%0d cnt=%0d want 1,0,128,%0d",
                  done, busy, prog_ctr, instr_cnt, exp_cnt(128));
      end
      step();
      n_cmp++;
      if (done !== 1'b1 || prog_ctr !== 12'd128) begin
         n_bad++;
         $display("FAIL done_hold got done=%b pc=%0d want 1,128", done, prog_ctr);
      end
   endtask

   task automatic test_priority();
      go(); step();
      absjump_en = 1; reljump_en = 1; target = 12'd100; step(); idle_ctl();
      n_cmp++;
      if (prog_ctr !== 12'd100) begin
         n_bad++; $display("FAIL abs_over_rel got pc=%0d want 100", prog_ctr);
      end
      reljump_en = 1; target = 12'hFFE; step(); idle_ctl();
      n_cmp++;
      if (prog_ctr !== 12'd98) begin
         n_bad++; $display("FAIL rel_neg got pc=%0d want 98", prog_ctr);
      end
      call_en = 1; absjump_en = 1; target = 12'd60; step(); idle_ctl();
      n_cmp++;
      if (prog_ctr !== 12'd60) begin
         n_bad++; $display("FAIL call_over_abs got pc=%0d want 60", prog_ctr);
      end
      ret_en = 1; call_en = 1; absjump_en = 1; target = 12'd5; step(); idle_ctl();
      n_cmp++;
      if (prog_ctr !== 12'd99 || stack_ovf !== 1'b0 || stack_unf !== 1'b0) begin
         n_bad++;
         $display("FAIL ret_over_all got pc=%0d ovf=%b unf=%b want 99,0,0", prog_ctr, stack_ovf, stack_unf);
      end
   endtask

   task automatic test_wrap();
      go();
      absjump_en = 1; target = 12'd4095; step(); idle_ctl();
      n_cmp++;
      if (prog_ctr !== 12'd4095) begin
         n_bad++; $display("FAIL abs_max got pc=%0d want 4095", prog_ctr);
      end
      step();
      n_cmp++;
      if (prog_ctr !== 12'd0) begin
         n_bad++; $display("FAIL inc_wrap got pc=%0d want 0", prog_ctr);
      end
      absjump_en = 1; target = 12'd4094; step(); idle_ctl();
      reljump_en = 1; target = 12'd3; step(); idle_ctl();
      n_cmp++;
      if (prog_ctr !== 12'd1) begin
         n_bad++; $display("FAIL rel_wrap_up got pc=%0d want 1", prog_ctr);
      end
      reljump_en = 1; target = 12'hFFD; step(); idle_ctl();
      n_cmp++;
      if (prog_ctr !== 12'd4094) begin
         n_bad++; $display("FAIL rel_wrap_down got pc=%0d want 4094", prog_ctr);
      end
   endtask

   task automatic test_call_ret();
      logic [11:0] pops [4] = '{12'd63, 12'd62, 12'd61, 12'd12};
      go();
      absjump_en = 1; target = 12'd10; step(); idle_ctl();
      call_en = 1; target = 12'd50; step(); idle_ctl();
      n_cmp++;
      if (prog_ctr !== 12'd50) begin
         n_bad++; $display("FAIL call_target got pc=%0d want 50", prog_ctr);
      end
      ret_en = 1; step(); idle_ctl();
      n_cmp++;
      if (prog_ctr !== 12'd11) begin
         n_bad++; $display("FAIL ret_addr got pc=%0d want 11", prog_ctr);
      end
      for (int i = 0; i < 4; i++) begin
         call_en = 1; target = 12'(60 + i); step(); idle_ctl();
      end
      n_cmp++;
      if (prog_ctr !== 12'd63 || stack_ovf !== 1'b0) begin
         n_bad++; $display("FAIL nest4 got pc=%0d ovf=%b want 63,0", prog_ctr, stack_ovf);
      end
      call_en = 1; target = 12'd70; step(); idle_ctl();
      n_cmp++;
      if (prog_ctr !== 12'd70 || stack_ovf !== 1'b1) begin
         n_bad++; $display("FAIL overflow got pc=%0d ovf=%b want 70,1", prog_ctr, stack_ovf);
      end
      for (int i = 0; i < 4; i++) begin
         ret_en = 1; step(); idle_ctl();
         n_cmp++;
         if (prog_ctr !== pops[i]) begin
            n_bad++; $display("FAIL pop_order got pc=%0d want %0d", prog_ctr, pops[i]);
         end
      end
      ret_en = 1; step(); idle_ctl();
      n_cmp++;
      if (prog_ctr !== 12'd13 || stack_unf !== 1'b1 || stack_ovf !== 1'b1) begin
         n_bad++;
         $display("FAIL underflow got pc=%0d unf=%b ovf=%b want 13,1,1", prog_ctr, stack_unf, stack_ovf);
      end
   endtask

   task automatic test_stall();
      go();
      absjump_en = 1; target = 12'd20; step(); idle_ctl();
      stall = 1; absjump_en = 1; ret_en = 1; target = 12'd99;
      for (int i = 0; i < 3; i++) begin
         step();
         n_cmp++;
         if (prog_ctr !== 12'd20 || instr_cnt !== exp_cnt(1) || stack_unf !== 1'b0) begin
            n_bad++;
            $display("FAIL stall_hold got pc=%0d cnt=%0d unf=%b want 20,%0d,0",
                     prog_ctr, instr_cnt, stack_unf, exp_cnt(1));
         end
      end
      idle_ctl(); step();
      n_cmp++;
      if (prog_ctr !== 12'd21 || instr_cnt !== exp_cnt(2)) begin
         n_bad++;
         $display("FAIL stall_release got pc=%0d cnt=%0d want 21,%0d", prog_ctr, instr_cnt, exp_cnt(2));
      end
      absjump_en = 1; target = 12'd128; step(); idle_ctl();
      stall = 1;
      repeat (2) begin
         step();
         n_cmp++;
         if (busy !== 1'b1 || done !== 1'b0 || prog_ctr !== 12'd128) begin
            n_bad++;
            $display("FAIL stall_at_end got busy=%b done=%b pc=%0d want 1,0,128", busy, done, prog_ctr);
         end
      end
      stall = 0; step();
      n_cmp++;
      if (done !== 1'b1 || instr_cnt !== exp_cnt(3)) begin
         n_bad++;
         $display("FAIL end_after_stall got done=%b cnt=%0d want 1,%0d", done, instr_cnt, exp_cnt(3));
      end
   endtask

   task automatic test_restart();
      go();
      ret_en = 1; step(); idle_ctl();
      repeat (5) begin
         call_en = 1; target = 12'd7; step(); idle_ctl();
      end
      absjump_en = 1; target = 12'd128; step(); idle_ctl();
      step();
      n_cmp++;
      if (done !== 1'b1 || stack_ovf !== 1'b1 || stack_unf !== 1'b1 || prog_ctr !== 12'd128) begin
         n_bad++;
         $display("FAIL done_flags got done=%b ovf=%b unf=%b pc=%0d want 1,1,1,128",
                  done, stack_ovf, stack_unf, prog_ctr);
      end
      req = 1; step();
      n_cmp++;
      if (busy !== 1'b1 || done !== 1'b0 || prog_ctr !== 12'd0 || stack_ovf !== 1'b0 ||
          stack_unf !== 1'b0 || instr_cnt !== 32'd0) begin
         n_bad++;
         $display("FAIL restart got busy=%b done=%b pc=%0d ovf=%b unf=%b cnt=%0d want 1,0,0,0,0,0",
                  busy, done, prog_ctr, stack_ovf, stack_unf, instr_cnt);
      end
      absjump_en = 1; target = 12'd128; step(); absjump_en = 0;
      step();
      n_cmp++;
      if (done !== 1'b1) begin
         n_bad++; $display("FAIL rearm_done got done=%b want 1", done);
      end
      step();
      n_cmp++;
      if (busy !== 1'b1 || prog_ctr !== 12'd0) begin
         n_bad++; $display("FAIL rearm_run got busy=%b pc=%0d want 1,0", busy, prog_ctr);
      end
      idle_ctl();
      call_en = 1; target = 12'd40; step(); idle_ctl();
      n_cmp++;
      if (prog_ctr !== 12'd40 || stack_ovf !== 1'b0) begin
         n_bad++; $display("FAIL stack_cleared got pc=%0d ovf=%b want 40,0", prog_ctr, stack_ovf);
      end
   endtask

   initial begin
      test_reset();
      test_run_to_end();
      test_priority();
      test_wrap();
      test_call_ret();
      test_stall();
      test_restart();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
